// File: rtl/dfi_refresh_arbiter.sv
// DFI command-slot arbiter between the read/write path and a periodic refresh engine.
// Define DFI_REF_BURST_EN to drain a refresh backlog as back-to-back REFs without extra PREAs.
module dfi_refresh_arbiter #(
    parameter int T_REFI       = 6240,
    parameter int T_RP         = 11,
    parameter int T_RFC        = 208,
    parameter int MAX_POSTPONE = 8
) (
    input  logic        core_clk,
    input  logic        core_arstn,
    input  logic        init_done,
    input  logic        rw_valid,
    output logic        rw_ready,
    input  logic [3:0]  rw_cmd,
    input  logic [2:0]  rw_bank,
    input  logic [15:0] rw_addr,
    output logic        cmd_valid,
    output logic [3:0]  cmd,
    output logic [2:0]  cmd_bank,
    output logic [15:0] cmd_addr,
    output logic [3:0]  ref_pending,
    output logic        ref_urgent,
    output logic        ref_overflow
);

    localparam int DLY_MAX = (T_RP > T_RFC) ? T_RP : T_RFC;
    localparam int DLY_W   = $clog2(DLY_MAX) + 1;
    localparam int REFI_W  = $clog2(T_REFI);

    localparam logic [DLY_W-1:0]  RP_LOAD   = DLY_W'((T_RP >= 2) ? T_RP - 2 : 0);
    localparam logic [DLY_W-1:0]  RFC_LOAD  = DLY_W'((T_RFC >= 2) ? T_RFC - 2 : 0);
    localparam logic [REFI_W-1:0] REFI_LAST = REFI_W'(T_REFI - 1);
    localparam logic [3:0]        PEND_MAX  = 4'(MAX_POSTPONE);

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PREA = 4'b0010;
    localparam logic [3:0] CMD_REF  = 4'b0001;

    typedef enum logic [2:0] {IDLE, PREA, WAIT_RP, REF, WAIT_RFC} state_t;

    state_t              state;
    logic [DLY_W-1:0]    dly;
    logic [REFI_W-1:0]   refi_cnt;
    logic                tick;
    logic                refresh_go;
    logic                rp_exit;
    logic                rfc_exit;
    logic                burst_ok;
    logic                ref_issue;
    logic                ovf_set;
    logic [3:0]          pend_nxt;

    // Backlog counter: a tick and a REF in the same cycle cancel out.
    function automatic logic [3:0] sat_pending(input logic [3:0] pend, input logic inc,
                                               input logic dec);
        logic [3:0] nxt;
        nxt = pend;
        if (inc && !dec && pend != PEND_MAX)
            nxt = pend + 4'd1;
        else if (dec && !inc && pend != 4'd0)
            nxt = pend - 4'd1;
        return nxt;
    endfunction

    always_comb begin
        tick       = init_done && (refi_cnt == REFI_LAST);
        refresh_go = ref_urgent || (ref_pending != 4'd0 && !rw_valid);
        rp_exit    = (state == PREA && T_RP == 1) || (state == WAIT_RP && dly == '0);
        rfc_exit   = (state == REF && T_RFC == 1) || (state == WAIT_RFC && dly == '0);
`ifdef DFI_REF_BURST_EN
        // Banks stay precharged after REF, so a backlog can go straight to the next REF.
        burst_ok   = (ref_pending != 4'd0) && (!rw_valid || ref_urgent);
`else
        burst_ok   = 1'b0;
`endif
        ref_issue  = init_done && (rp_exit || (rfc_exit && burst_ok));
        ovf_set    = tick && !ref_issue && (ref_pending == PEND_MAX);
        pend_nxt   = sat_pending(ref_pending, tick, ref_issue);
    end

    assign rw_ready = core_arstn && init_done && (state == IDLE) && !refresh_go;

    always_ff @(posedge core_clk or negedge core_arstn) begin
        if (!core_arstn) begin
            refi_cnt     <= '0;
            ref_pending  <= 4'd0;
            ref_urgent   <= 1'b0;
            ref_overflow <= 1'b0;
        end else if (!init_done) begin
            refi_cnt     <= '0;
            ref_pending  <= 4'd0;
            ref_urgent   <= 1'b0;
        end else begin
            refi_cnt     <= tick ? '0 : refi_cnt + REFI_W'(1);
            ref_pending  <= pend_nxt;
            ref_urgent   <= (pend_nxt == PEND_MAX);
            if (ovf_set)
                ref_overflow <= 1'b1;
        end
    end

    always_ff @(posedge core_clk or negedge core_arstn) begin
        if (!core_arstn) begin
            state     <= IDLE;
            dly       <= '0;
            cmd_valid <= 1'b0;
            cmd       <= CMD_NOP;
            cmd_bank  <= '0;
            cmd_addr  <= '0;
        end else if (!init_done) begin
            state     <= IDLE;
            dly       <= '0;
            cmd_valid <= 1'b0;
            cmd       <= CMD_NOP;
            cmd_bank  <= '0;
            cmd_addr  <= '0;
        end else begin
            cmd_valid <= 1'b0;
            cmd       <= CMD_NOP;
            cmd_bank  <= '0;
            cmd_addr  <= '0;
            if (ref_issue) begin
                state     <= REF;
                cmd_valid <= 1'b1;
                cmd       <= CMD_REF;
            end else begin
                case (state)
                    IDLE: begin
                        if (refresh_go) begin
                            state     <= PREA;
                            cmd_valid <= 1'b1;
                            cmd       <= CMD_PREA;
                            cmd_addr  <= 16'h0400;
                        end else if (rw_valid) begin
                            cmd_valid <= 1'b1;
                            cmd       <= rw_cmd;
                            cmd_bank  <= rw_bank;
                            cmd_addr  <= rw_addr;
                        end
                    end
                    PREA: begin
                        state <= WAIT_RP;
                        dly   <= RP_LOAD;
                    end
                    WAIT_RP: dly <= dly - DLY_W'(1);
                    REF: begin
                        if (rfc_exit) begin
                            state <= IDLE;
                        end else begin
                            state <= WAIT_RFC;
                            dly   <= RFC_LOAD;
                        end
                    end
                    WAIT_RFC: begin
                        if (rfc_exit)
                            state <= IDLE;
                        else
                            dly <= dly - DLY_W'(1);
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
